block_ram_stream_port: RTL and testbench

- Request/response stream front-end placed directly upstream of the single-port block RAM; drives its ADDR/DI/WE and consumes its 1-cycle-latency DO.
- Turns the RAM's fixed-latency, no-backpressure read port into a valid/ready interface.
- A 2-entry response buffer absorbs read data while the consumer stalls; credit logic prevents overflow.
- Used wherever a pipeline stage or arbiter needs stall-tolerant access to a block RAM.

---
 rtl/block_ram_stream_port.sv | 145 ++++++++++++++
 tb/tb_block_ram_stream_port.sv | 216 +++++++++++++++++++++
 2 files changed

// File: rtl/block_ram_stream_port.sv
// Valid/ready request/response front-end for a single-port, 1-cycle-latency block RAM.
// Optional macro BRAM_STREAM_WRITE_ACK_EN: writes take a credit and return an ack response (RESP_WACK=1).
module block_ram_stream_port #(
    parameter int ADDR_WIDTH = 1,
    parameter int DATA_WIDTH = 1
) (
    input  logic                  CLK,
    input  logic                  RESET,
    input  logic                  REQ_VALID,
    output logic                  REQ_READY,
    input  logic                  REQ_WE,
    input  logic [ADDR_WIDTH-1:0] REQ_ADDR,
    input  logic [DATA_WIDTH-1:0] REQ_DATA,
    output logic [ADDR_WIDTH-1:0] RAM_ADDR,
    output logic [DATA_WIDTH-1:0] RAM_DI,
    output logic                  RAM_WE,
    input  logic [DATA_WIDTH-1:0] RAM_DO,
    output logic                  RESP_VALID,
    input  logic                  RESP_READY,
`ifdef BRAM_STREAM_WRITE_ACK_EN
    output logic                  RESP_WACK,
`endif
    output logic [DATA_WIDTH-1:0] RESP_DATA
);

    // Handshake: a request transfers in a cycle with REQ_VALID && REQ_READY,
    // a response transfers in a cycle with RESP_VALID && RESP_READY.
    logic                  inflight_q;
    logic [1:0]            occ_q, occ_d;
    logic [DATA_WIDTH-1:0] head_q, head_d;
    logic [DATA_WIDTH-1:0] skid_q, skid_d;
    logic [DATA_WIDTH-1:0] push_data;
    logic [1:0]            pending;
    logic                  accept;
    logic                  issue;
    logic                  push;
    logic                  pop;
    logic                  resp_valid;

`ifdef BRAM_STREAM_WRITE_ACK_EN
    logic                  inflight_wack_q;
    logic [DATA_WIDTH-1:0] wdata_q;
    logic                  head_wack_q, head_wack_d;
    logic                  skid_wack_q, skid_wack_d;
    logic                  push_wack;
`endif

    assign pending    = occ_q + {1'b0, inflight_q};
    assign resp_valid = !RESET && (occ_q != 2'd0);
    assign pop        = resp_valid && RESP_READY;
    assign push       = inflight_q;

    // Credit: never let buffered plus in-flight responses exceed the two buffer slots.
    assign REQ_READY  = !RESET && ((pending < 2'd2) || ((pending == 2'd2) && pop));
    assign accept     = REQ_VALID && REQ_READY;

`ifdef BRAM_STREAM_WRITE_ACK_EN
    assign issue      = accept;
    assign push_data  = inflight_wack_q ? wdata_q : RAM_DO;
    assign push_wack  = inflight_wack_q;
    assign RESP_WACK  = head_wack_q;
`else
    assign issue      = accept && !REQ_WE;
    assign push_data  = RAM_DO;
`endif

    assign RAM_ADDR   = REQ_ADDR;
    assign RAM_DI     = REQ_DATA;
    assign RAM_WE     = accept && REQ_WE;
    assign RESP_VALID = resp_valid;
    assign RESP_DATA  = head_q;

    always_comb begin
        occ_d  = occ_q;
        head_d = head_q;
        skid_d = skid_q;
`ifdef BRAM_STREAM_WRITE_ACK_EN
        head_wack_d = head_wack_q;
        skid_wack_d = skid_wack_q;
`endif
        case ({push, pop})
            2'b10: begin
                if (occ_q == 2'd0) begin
                    head_d = push_data;
`ifdef BRAM_STREAM_WRITE_ACK_EN
                    head_wack_d = push_wack;
`endif
                end else begin
                    skid_d = push_data;
`ifdef BRAM_STREAM_WRITE_ACK_EN
                    skid_wack_d = push_wack;
`endif
                end
                occ_d = occ_q + 2'd1;
            end
            2'b01: begin
                head_d = skid_q;
`ifdef BRAM_STREAM_WRITE_ACK_EN
                head_wack_d = skid_wack_q;
`endif
                occ_d = occ_q - 2'd1;
            end
            2'b11: begin
                // Occupancy unchanged; with a single entry the new data bypasses the skid slot.
                if (occ_q == 2'd1) begin
                    head_d = push_data;
`ifdef BRAM_STREAM_WRITE_ACK_EN
                    head_wack_d = push_wack;
`endif
                end else begin
                    head_d = skid_q;
                    skid_d = push_data;
`ifdef BRAM_STREAM_WRITE_ACK_EN
                    head_wack_d = skid_wack_q;
                    skid_wack_d = push_wack;
`endif
                end
            end
            default: ;
        endcase
    end

    always_ff @(posedge CLK) begin
        if (RESET) begin
            inflight_q <= 1'b0;
            occ_q      <= 2'd0;
        end else begin
            inflight_q <= issue;
            occ_q      <= occ_d;
        end
    end

    // Payload registers need no reset: occupancy alone decides what is visible.
    always_ff @(posedge CLK) begin
        head_q <= head_d;
        skid_q <= skid_d;
`ifdef BRAM_STREAM_WRITE_ACK_EN
        head_wack_q     <= head_wack_d;
        skid_wack_q     <= skid_wack_d;
        inflight_wack_q <= REQ_WE;
        wdata_q         <= REQ_DATA;
`endif
    end

endmodule

// File: tb/tb_block_ram_stream_port.sv
// Bench for block_ram_stream_port: table-driven directed vectors, hand sequences and a randomized
// run against a queue-based reference model; a behavioural 1-cycle-latency RAM is attached.
module tb_block_ram_stream_port;

    localparam int AW = 4;
    localparam int DW = 8;

    logic          clk = 1'b0;
    logic          rst;
    logic          req_valid, req_ready, req_we;
    logic [AW-1:0] req_addr, ram_addr;
    logic [DW-1:0] req_data, ram_di, ram_do, resp_data;
    logic          ram_we;
    logic          resp_valid, resp_ready;
    logic          resp_wack;

    int tests = 0;
    int fails = 0;

    block_ram_stream_port #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) dut (
        .CLK(clk), .RESET(rst),
        .REQ_VALID(req_valid), .REQ_READY(req_ready), .REQ_WE(req_we),
        .REQ_ADDR(req_addr), .REQ_DATA(req_data),
        .RAM_ADDR(ram_addr), .RAM_DI(ram_di), .RAM_WE(ram_we), .RAM_DO(ram_do),
        .RESP_VALID(resp_valid), .RESP_READY(resp_ready),
`ifdef BRAM_STREAM_WRITE_ACK_EN
        .RESP_WACK(resp_wack),
`endif
        .RESP_DATA(resp_data)
    );

`ifndef BRAM_STREAM_WRITE_ACK_EN
    assign resp_wack = 1'b0;
`endif

    // Clock and the attached RAM (read-first, 1-cycle read latency).
    always #5 clk = ~clk;

    logic [DW-1:0] ram_mem [16];
    always @(posedge clk) begin
        if (ram_we) ram_mem[ram_addr] <= ram_di;
        ram_do <= ram_mem[ram_addr];
    end

    // Reference model: expected responses in order, each with the cycle it may first appear.
    logic [DW:0]   exp_q [$];
    int            due_q [$];
    logic [DW-1:0] model_mem [16];
    int            cyc = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Inputs change just after the falling edge; outputs are sampled 1ns later.
    task automatic drive(input logic r, input logic v, input logic we, input logic [AW-1:0] a,
                         input logic [DW-1:0] d, input logic rr);
        @(negedge clk);
        rst = r; req_valid = v; req_we = we; req_addr = a; req_data = d; resp_ready = rr;
        #1;
    endtask

    task automatic step(input logic v, input logic we, input logic [AW-1:0] a,
                        input logic [DW-1:0] d, input logic rr);
        logic exp_rv, exp_rdy;
        drive(1'b0, v, we, a, d, rr);
        exp_rv  = (exp_q.size() > 0) && (cyc >= due_q[0]);
        exp_rdy = (exp_q.size() < 2) || ((exp_q.size() == 2) && exp_rv && rr);
        check("rnd_req_ready", req_ready, exp_rdy);
        check("rnd_resp_valid", resp_valid, exp_rv);
        check("rnd_ram_we", ram_we, v && exp_rdy && we);
        check("rnd_ram_addr", ram_addr, a);
        if (exp_rv) begin
            check("rnd_resp_data", resp_data, exp_q[0][DW-1:0]);
            check("rnd_resp_wack", resp_wack, exp_q[0][DW]);
        end
        if (exp_rv && rr) begin
            void'(exp_q.pop_front());
            void'(due_q.pop_front());
        end
        if (v && exp_rdy) begin
            if (we) begin
                model_mem[a] = d;
`ifdef BRAM_STREAM_WRITE_ACK_EN
                exp_q.push_back({1'b1, d});
                due_q.push_back(cyc + 2);
`endif
            end else begin
                exp_q.push_back({1'b0, model_mem[a]});
                due_q.push_back(cyc + 2);
            end
        end
        cyc++;
    endtask

    typedef struct {
        logic          v;
        logic          we;
        logic [AW-1:0] a;
        logic [DW-1:0] d;
        logic          rr;
        logic          e_rdy;
        logic          e_we;
        logic          e_rv;
        logic [DW-1:0] e_data;
    } vec_t;

    vec_t tbl [$];

    initial begin
        rst = 1'b1; req_valid = 1'b0; req_we = 1'b0; req_addr = '0; req_data = '0; resp_ready = 1'b0;

        // Reset held for three cycles with a request pending.
        for (int i = 0; i < 3; i++) begin
            drive(1'b1, 1'b1, 1'b1, 4'd3, 8'h55, 1'b1);
            check("rst_req_ready", req_ready, 1'b0);
            check("rst_ram_we", ram_we, 1'b0);
            check("rst_resp_valid", resp_valid, 1'b0);
        end
        drive(1'b0, 1'b0, 1'b0, 4'd0, 8'h00, 1'b1);
        check("ready_after_reset", req_ready, 1'b1);

`ifndef BRAM_STREAM_WRITE_ACK_EN
        // Write-then-read, then backpressure on three reads.
        tbl.push_back('{1, 1, 4'd5, 8'hA5, 1, 1, 1, 0, 8'h00});
        tbl.push_back('{1, 0, 4'd5, 8'h00, 1, 1, 0, 0, 8'h00});
        tbl.push_back('{0, 0, 4'd0, 8'h00, 1, 1, 0, 0, 8'h00});
        tbl.push_back('{0, 0, 4'd0, 8'h00, 1, 1, 0, 1, 8'hA5});
        tbl.push_back('{0, 0, 4'd0, 8'h00, 1, 1, 0, 0, 8'h00});
        tbl.push_back('{1, 1, 4'd1, 8'h11, 1, 1, 1, 0, 8'h00});
        tbl.push_back('{1, 1, 4'd2, 8'h22, 1, 1, 1, 0, 8'h00});
        tbl.push_back('{1, 1, 4'd3, 8'h33, 1, 1, 1, 0, 8'h00});
        tbl.push_back('{1, 0, 4'd1, 8'h00, 0, 1, 0, 0, 8'h00});
        tbl.push_back('{1, 0, 4'd2, 8'h00, 0, 1, 0, 0, 8'h00});
        tbl.push_back('{1, 0, 4'd3, 8'h00, 0, 0, 0, 1, 8'h11});
        tbl.push_back('{1, 0, 4'd3, 8'h00, 0, 0, 0, 1, 8'h11});
        tbl.push_back('{1, 0, 4'd3, 8'h00, 0, 0, 0, 1, 8'h11});
        tbl.push_back('{1, 0, 4'd3, 8'h00, 1, 1, 0, 1, 8'h11});
        tbl.push_back('{0, 0, 4'd0, 8'h00, 1, 1, 0, 1, 8'h22});
        tbl.push_back('{0, 0, 4'd0, 8'h00, 1, 1, 0, 1, 8'h33});
        tbl.push_back('{0, 0, 4'd0, 8'h00, 1, 1, 0, 0, 8'h00});
        foreach (tbl[i]) begin
            drive(1'b0, tbl[i].v, tbl[i].we, tbl[i].a, tbl[i].d, tbl[i].rr);
            check("tbl_req_ready", req_ready, tbl[i].e_rdy);
            check("tbl_ram_we", ram_we, tbl[i].e_we);
            check("tbl_resp_valid", resp_valid, tbl[i].e_rv);
            if (tbl[i].e_rv) check("tbl_resp_data", resp_data, tbl[i].e_data);
        end
`else
        // Write ack followed by a read of the same address.
        drive(1'b0, 1'b1, 1'b1, 4'd2, 8'h3C, 1'b1);
        check("wack_w_ready", req_ready, 1'b1);
        drive(1'b0, 1'b1, 1'b0, 4'd2, 8'h00, 1'b1);
        check("wack_r_ready", req_ready, 1'b1);
        check("wack_rv0", resp_valid, 1'b0);
        drive(1'b0, 1'b0, 1'b0, 4'd0, 8'h00, 1'b1);
        check("wack_rv1", resp_valid, 1'b1);
        check("wack_flag1", resp_wack, 1'b1);
        check("wack_data1", resp_data, 8'h3C);
        drive(1'b0, 1'b0, 1'b0, 4'd0, 8'h00, 1'b1);
        check("wack_rv2", resp_valid, 1'b1);
        check("wack_flag2", resp_wack, 1'b0);
        check("wack_data2", resp_data, 8'h3C);
        drive(1'b0, 1'b0, 1'b0, 4'd0, 8'h00, 1'b1);
        check("wack_rv3", resp_valid, 1'b0);
`endif

        // Streaming: preload 0..7, then eight back-to-back reads.
        for (int i = 0; i < 8; i++) drive(1'b0, 1'b1, 1'b1, 4'(i), 8'(8'h10 + i), 1'b1);
        for (int i = 0; i < 4; i++) drive(1'b0, 1'b0, 1'b0, 4'd0, 8'h00, 1'b1);
        for (int k = 0; k < 11; k++) begin
            drive(1'b0, k < 8, 1'b0, 4'(k), 8'h00, 1'b1);
            if (k < 8) check("stream_req_ready", req_ready, 1'b1);
            if (k >= 2 && k < 10) begin
                check("stream_resp_valid", resp_valid, 1'b1);
                check("stream_resp_data", resp_data, 8'(8'h10 + k - 2));
            end
            if (k == 10) check("stream_end_valid", resp_valid, 1'b0);
        end

        // Reset with occ=1/inflight=1, then with occ=2: nothing stale may emerge.
        for (int s = 0; s < 2; s++) begin
            drive(1'b0, 1'b1, 1'b0, 4'd1, 8'h00, 1'b0);
            drive(1'b0, 1'b1, 1'b0, 4'd2, 8'h00, 1'b0);
            if (s == 1) drive(1'b0, 1'b0, 1'b0, 4'd0, 8'h00, 1'b0);
            drive(1'b1, 1'b1, 1'b0, 4'd3, 8'h00, 1'b1);
            check("midrst_resp_valid", resp_valid, 1'b0);
            check("midrst_req_ready", req_ready, 1'b0);
            for (int i = 0; i < 5; i++) begin
                drive(1'b0, 1'b0, 1'b0, 4'd0, 8'h00, 1'b1);
                check("postrst_resp_valid", resp_valid, 1'b0);
                if (i == 0) check("postrst_req_ready", req_ready, 1'b1);
            end
        end

        // Randomized run against the reference model.
        exp_q.delete();
        due_q.delete();
        for (int i = 0; i < 16; i++) step(1'b1, 1'b1, 4'(i), 8'($urandom_range(0, 255)), 1'b1);
        for (int i = 0; i < 4; i++) step(1'b0, 1'b0, 4'd0, 8'h00, 1'b1);
        for (int i = 0; i < 3000; i++) begin
            step($urandom_range(0, 3) != 0, $urandom_range(0, 3) == 0,
                 4'($urandom_range(0, 15)), 8'($urandom_range(0, 255)),
                 $urandom_range(0, 3) != 0);
        end
        for (int i = 0; i < 6; i++) step(1'b0, 1'b0, 4'd0, 8'h00, 1'b1);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
